// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with an 8-bit register file, local read port and write strobe
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         REG_AW   = 4
) (
    input  logic              clk100,
    input  logic              sys_rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic [REG_AW-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    output logic              wr_pulse,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** REG_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_REGA, S_WR, S_RD, S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        scl_sync, sda_sync;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [REG_AW-1:0] pointer;
    logic              scl_fall_q;
    logic [7:0]        regs [DEPTH];

    // [1] is the synchronized level, [2] the previous one for edge detection
    wire scl_now   = scl_sync[1];
    wire scl_prev  = scl_sync[2];
    wire sda_now   = sda_sync[1];
    wire sda_prev  = sda_sync[2];
    wire scl_rise  = scl_now & ~scl_prev;
    wire scl_fall  = ~scl_now & scl_prev;
    wire start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    wire stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    wire [7:0]        byte_in   = {shift[6:0], sda_now};
    wire              dev_match = (byte_in[7:1] == DEV_ADDR);
    wire [REG_AW-1:0] ptr_inc   = pointer + 1'b1;

    assign loc_rdata = regs[loc_addr];

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
            state_q  <= S_IDLE;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_DEV;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else if (scl_rise) begin
            unique case (state_q)
                S_DEV: begin
                    if (bit_cnt == 4'd7 && !dev_match) state_d = S_IDLE;
                    else if (bit_cnt == 4'd8)          state_d = shift[0] ? S_RD : S_REGA;
                end
                S_REGA:  if (bit_cnt == 4'd8) state_d = S_WR;
                S_RD:    if (bit_cnt == 4'd8 && sda_now) state_d = S_WAIT;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            pointer    <= '0;
            scl_fall_q <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_pulse   <= 1'b0;
            scl_fall_q <= scl_fall;
            if (start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (scl_rise && state_q != S_IDLE && state_q != S_WAIT) begin
                    if (bit_cnt != 4'd8) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            unique case (state_q)
                                S_DEV:  busy <= dev_match;
                                S_REGA: pointer <= byte_in[REG_AW-1:0];
                                S_WR: begin
                                    regs[pointer] <= byte_in;
                                    wr_pulse      <= 1'b1;
                                    wr_addr       <= pointer;
                                    wr_data       <= byte_in;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        // ACK slot: shift[0] still holds the R/W bit in DEV
                        bit_cnt <= '0;
                        unique case (state_q)
                            S_DEV: if (shift[0]) shift <= regs[pointer];
                            S_WR:  pointer <= ptr_inc;
                            S_RD: begin
                                if (!sda_now) begin
                                    pointer <= ptr_inc;
                                    shift   <= regs[ptr_inc];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (scl_fall_q) begin
                    unique case (state_q)
                        S_DEV, S_REGA, S_WR: sda_oe <= (bit_cnt == 4'd8);
                        S_RD:                sda_oe <= (bit_cnt != 4'd8) & ~shift[7];
                        default:             sda_oe <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule
